// File: rtl/led_status_pkg.sv
// led_status_pkg: mode encodings, ramp direction type and counter-width helper
// shared by the LED status PWM driver. Revision: 1.0
`default_nettype none

package led_status_pkg;

  localparam logic [1:0] LED_MODE_OFF     = 2'b00;
  localparam logic [1:0] LED_MODE_STATIC  = 2'b01;
  localparam logic [1:0] LED_MODE_BLINK   = 2'b10;
  localparam logic [1:0] LED_MODE_BREATHE = 2'b11;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_dir_e;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: per-channel frame latch, duty select and registered compare.
// Optional macro LED_STATUS_PWM_GAMMA_EN applies a gamma-2 duty curve. Revision: 1.0
`default_nettype none

module led_pwm_channel
  import led_status_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_fb,
  input  logic [PWM_BITS-1:0] i_level,
  input  logic [1:0]          i_mode,
  input  logic                i_phase,
  input  logic [PWM_BITS-1:0] i_ramp,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  logic [PWM_BITS-1:0]   r_level;
  logic [1:0]            r_mode;
  logic                  r_led;
  logic [PWM_BITS-1:0]   w_duty_lin;
  logic [PWM_BITS-1:0]   w_duty;
  logic [PWM_BITS-1:0]   w_brth_duty;
  logic [2*PWM_BITS-1:0] w_lvl_ext;
  logic [2*PWM_BITS-1:0] w_ramp_ext;
  logic                  w_lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
      r_mode  <= LED_MODE_OFF;
    end else if (i_fb) begin
      r_level <= i_level;
      r_mode  <= i_mode;
    end
  end

  assign w_lvl_ext   = {{PWM_BITS{1'b0}}, r_level};
  assign w_ramp_ext  = {{PWM_BITS{1'b0}}, i_ramp};
  assign w_brth_duty = PWM_BITS'((w_lvl_ext * w_ramp_ext) >> PWM_BITS);

  always_comb begin
    w_duty_lin = '0;
    case (r_mode)
      LED_MODE_STATIC:  w_duty_lin = r_level;
      LED_MODE_BLINK:   w_duty_lin = i_phase ? r_level : '0;
      LED_MODE_BREATHE: w_duty_lin = w_brth_duty;
      default:          w_duty_lin = '0;
    endcase
  end

`ifdef LED_STATUS_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_duty_ext;
  logic [PWM_BITS-1:0]   w_duty_sq;

  assign w_duty_ext = {{PWM_BITS{1'b0}}, w_duty_lin};
  assign w_duty_sq  = PWM_BITS'((w_duty_ext * w_duty_ext) >> PWM_BITS);
  // Full scale bypasses the curve so 100% stays 100%.
  assign w_duty     = (&w_duty_lin) ? w_duty_lin : w_duty_sq;
`else
  assign w_duty = w_duty_lin;
`endif

  assign w_lit = (&w_duty) | (i_pwm_cnt < w_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= ACTIVE_LOW;
    end else begin
      r_led <= w_lit ^ ACTIVE_LOW;
    end
  end

  assign o_led = r_led;

endmodule

`default_nettype wire

// File: rtl/led_status_pwm.sv
// led_status_pwm: N-channel status LED PWM driver with off/static/blink/breathe
// modes and frame-aligned updates. Optional macro LED_STATUS_PWM_GAMMA_EN. Revision: 1.0
`default_nettype none

module led_status_pwm
  import led_status_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PWM_BITS    = 8,
  parameter int PRESCALE    = 4,
  parameter int BLINK_DIV   = 12207,
  parameter int BREATHE_DIV = 48,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                       clk25,
  input  logic                       rst,
  input  logic [NUM_CH*PWM_BITS-1:0] ch_level,
  input  logic [NUM_CH*2-1:0]        ch_mode,
  output logic [NUM_CH-1:0]          led_out,
  output logic                       frame_tick
);

  localparam int c_presc_w = cnt_width(PRESCALE);
  localparam int c_blink_w = cnt_width(BLINK_DIV);
  localparam int c_brth_w  = cnt_width(BREATHE_DIV);

  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
  localparam logic [c_brth_w-1:0]  c_brth_last  = c_brth_w'(BREATHE_DIV - 1);
  localparam logic [PWM_BITS-1:0]  c_pwm_max    = '1;
  localparam logic [PWM_BITS-1:0]  c_pwm_one    = PWM_BITS'(1);

  logic [c_presc_w-1:0] r_presc;
  logic [PWM_BITS-1:0]  r_pwm_cnt;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_phase;
  logic [c_brth_w-1:0]  r_brth_cnt;
  logic [PWM_BITS-1:0]  r_ramp;
  ramp_dir_e            r_ramp_dir;
  logic                 r_frame_tick;
  logic                 w_tick;
  logic                 w_fb;
  logic [NUM_CH-1:0]    w_led;

  assign w_tick = (r_presc == c_presc_last);
  assign w_fb   = w_tick && (r_pwm_cnt == c_pwm_max);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_pwm_cnt     <= '0;
      r_frame_tick  <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_brth_cnt    <= '0;
      r_ramp        <= '0;
      r_ramp_dir    <= RAMP_UP;
    end else begin
      r_frame_tick <= w_fb;

      if (w_tick) begin
        r_presc   <= '0;
        r_pwm_cnt <= r_pwm_cnt + c_pwm_one;
      end else begin
        r_presc <= r_presc + c_presc_w'(1);
      end

      if (w_fb) begin
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
        end

        // Direction flips as the ramp lands on an end value, so it never wraps.
        if (r_brth_cnt == c_brth_last) begin
          r_brth_cnt <= '0;
          if (r_ramp_dir == RAMP_UP) begin
            r_ramp <= r_ramp + c_pwm_one;
            if (r_ramp == c_pwm_max - c_pwm_one) r_ramp_dir <= RAMP_DOWN;
          end else begin
            r_ramp <= r_ramp - c_pwm_one;
            if (r_ramp == c_pwm_one) r_ramp_dir <= RAMP_UP;
          end
        end else begin
          r_brth_cnt <= r_brth_cnt + c_brth_w'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      led_pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
        .clk       (clk25),
        .rst       (rst),
        .i_fb      (w_fb),
        .i_level   (ch_level[gi*PWM_BITS +: PWM_BITS]),
        .i_mode    (ch_mode[gi*2 +: 2]),
        .i_phase   (r_blink_phase),
        .i_ramp    (r_ramp),
        .i_pwm_cnt (r_pwm_cnt),
        .o_led     (w_led[gi])
      );
    end
  endgenerate

  assign led_out    = w_led;
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_status_pwm.sv
// tb_led_status_pwm: two configurations of led_status_pwm checked cycle by cycle
// against a frame-level reference model under directed and random stimulus.
`default_nettype none
`timescale 1ns/1ps

module tb_led_status_pwm;

  logic        clk25 = 1'b0;
  logic        rst;
  logic [11:0] ch_level;
  logic [5:0]  ch_mode;
  logic [2:0]  led_a, led_b;
  logic        ft_a, ft_b;

  int n_cmp = 0;
  int n_mis = 0;
  int n     = 0;

  int prs  [2] = '{1, 3};
  int bdiv [2] = '{2, 3};
  int rdiv [2] = '{1, 2};
  bit alow [2] = '{1'b1, 1'b0};

  logic [3:0] lat_lvl  [2][3];
  logic [1:0] lat_mode [2][3];

  always #5 clk25 = ~clk25;

  led_status_pwm #(
    .NUM_CH(3), .PWM_BITS(4), .PRESCALE(1), .BLINK_DIV(2), .BREATHE_DIV(1), .ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk25(clk25), .rst(rst), .ch_level(ch_level), .ch_mode(ch_mode),
    .led_out(led_a), .frame_tick(ft_a)
  );

  led_status_pwm #(
    .NUM_CH(3), .PWM_BITS(4), .PRESCALE(3), .BLINK_DIV(3), .BREATHE_DIV(2), .ACTIVE_LOW(1'b0)
  ) u_dut_b (
    .clk25(clk25), .rst(rst), .ch_level(ch_level), .ch_mode(ch_mode),
    .led_out(led_b), .frame_tick(ft_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h at n=%0d t=%0t", tag, obs, exp, n, $time);
    end
  endtask

  // Duty of one channel in frame f: blink phase and ramp follow from how many
  // frame boundaries have elapsed since reset.
  function automatic int model_duty(input logic [1:0] md, input logic [3:0] lv,
                                    input int f, input int bd, input int rd);
    int ph, s, r, d;
    ph = (f / bd) % 2;
    s  = (f / rd) % 30;
    r  = (s <= 15) ? s : 30 - s;
    case (md)
      2'b01:   d = int'(lv);
      2'b10:   d = (ph == 1) ? int'(lv) : 0;
      2'b11:   d = (int'(lv) * r) / 16;
      default: d = 0;
    endcase
`ifdef LED_STATUS_PWM_GAMMA_EN
    if (d != 15) d = (d * d) / 16;
`endif
    return d;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 3; c++) begin
        lat_lvl[d][c]  = 4'd0;
        lat_mode[d][c] = 2'b00;
      end
  endtask

  task automatic step();
    logic [2:0] led_exp;
    logic [2:0] led_obs;
    logic       ft_exp;
    logic       ft_obs;
    int m, f, pos, flen, dty;
    @(posedge clk25);
    n++;
    #1;
    for (int d = 0; d < 2; d++) begin
      flen    = 16 * prs[d];
      ft_exp  = (n % flen == 0);
      m       = n - 1;
      f       = m / flen;
      pos     = (m / prs[d]) % 16;
      for (int c = 0; c < 3; c++) begin
        dty = model_duty(lat_mode[d][c], lat_lvl[d][c], f, bdiv[d], rdiv[d]);
        led_exp[c] = ((dty == 15) || (pos < dty)) ^ alow[d];
      end
      led_obs = (d == 0) ? led_a : led_b;
      ft_obs  = (d == 0) ? ft_a : ft_b;
      check((d == 0) ? "A frame_tick" : "B frame_tick", 32'(ft_obs), 32'(ft_exp));
      check((d == 0) ? "A led_out" : "B led_out", 32'(led_obs), 32'(led_exp));
      if (n % flen == 0) begin
        for (int c = 0; c < 3; c++) begin
          lat_lvl[d][c]  = ch_level[c*4 +: 4];
          lat_mode[d][c] = ch_mode[c*2 +: 2];
        end
      end
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to_pos(input int p);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while ((n % 16 != p) && guard < 64);
    check("run_to_pos bound", 32'(n % 16), 32'(p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst led A", 32'(led_a), 32'h7);
    check("rst led B", 32'(led_b), 32'h0);
    check("rst tick A", 32'(ft_a), 32'h0);
    check("rst tick B", 32'(ft_b), 32'h0);
    @(posedge clk25);
    #1;
    rst = 1'b0;
    n   = 0;
    clear_model();
  endtask

  task automatic set_ch(input int c, input logic [3:0] lv, input logic [1:0] md);
    ch_level[c*4 +: 4] = lv;
    ch_mode[c*2 +: 2]  = md;
  endtask

  initial begin
    logic [3:0] rl;
    int         rc;
    rst      = 1'b1;
    ch_level = '0;
    ch_mode  = '0;
    clear_model();
    do_reset();

    set_ch(0, 4'd4, 2'b01);
    set_ch(1, 4'd8, 2'b01);
    set_ch(2, 4'd0, 2'b01);
    run(16 * 3 * 3);

    run_to_pos(5);
    set_ch(1, 4'd2, 2'b01);
    run(16 * 3 * 2);

    set_ch(0, 4'd15, 2'b01);
    set_ch(1, 4'd15, 2'b10);
    set_ch(2, 4'd15, 2'b11);
    run(16 * 3 * 24);

    run_to_pos(7);
    do_reset();
    run(16 * 3 * 4);

    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rc = $urandom_range(0, 2);
        case ($urandom_range(0, 3))
          0:       rl = 4'd0;
          1:       rl = 4'd15;
          default: rl = 4'($urandom);
        endcase
        set_ch(rc, rl, 2'($urandom));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
